// File: rtl/fetch_pc_queue_pkg.sv
// Shared CPU parameters and the fetch-request record.
// Imported by the fetch PC generator and its request queue.
package fetch_pc_queue_pkg;

    localparam int              WORD     = 32;
    localparam int              FETCH_W  = 2;
    localparam logic [WORD-1:0] RESET_PC = 32'h1C00_0000;

    typedef struct packed {
        logic [WORD-1:0]    pc;
        logic [FETCH_W-1:0] mask;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_PRE,
        RD_EX
    } redir_t;

endpackage

// File: rtl/fetch_pc_queue_fifo.sv
// Fetch request storage: circular buffer with count-based full/empty.
// The head entry comes straight from the storage registers.
module fetch_req_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch PC generator feeding a small request queue toward the ICache.
// Redirects seen during a stall are held and replayed once it lifts.
module fetch_pc_queue #(
    parameter int              WORD     = fetch_pc_queue_pkg::WORD,
    parameter int              FETCH_W  = fetch_pc_queue_pkg::FETCH_W,
    parameter int              DEPTH    = 4,
    parameter logic [WORD-1:0] RESET_PC = fetch_pc_queue_pkg::RESET_PC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_redirect,
    input  logic [WORD-1:0]        ex_pc,
    input  logic                   pre_redirect,
    input  logic [WORD-1:0]        pre_pc,
    input  logic                   stall_icache,
    input  logic                   stall_dcache,
    output logic                   req_valid,
    output logic [WORD-1:0]        req_pc,
    output logic [FETCH_W-1:0]     req_mask,
    input  logic                   req_ready,
    output logic [$clog2(DEPTH):0] occupancy
);

    import fetch_pc_queue_pkg::*;

    localparam int GB = FETCH_W * 4;
    localparam int OW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = WORD + FETCH_W;

    logic               stall;
    logic [WORD-1:0]    gen_pc;
    logic [WORD-1:0]    gen_next;
    logic [FETCH_W-1:0] gen_mask;
    logic               pend_valid;
    logic               pend_ex;
    logic [WORD-1:0]    pend_pc;
    redir_t             redir;
    logic [WORD-1:0]    redir_pc;
    logic               enq;
    logic               deq;
    logic               full;
    logic [EW-1:0]      head;

    assign stall    = stall_icache | stall_dcache;
    assign gen_next = (gen_pc & ~WORD'(GB - 1)) + WORD'(GB);

    // Slots below the entry offset within the group are masked off.
    if (FETCH_W == 1) begin : g_mask1
        assign gen_mask = '1;
    end else begin : g_maskn
        for (genvar i = 0; i < FETCH_W; i++) begin : g_bit
            assign gen_mask[i] = (i >= int'(gen_pc[OW+1:2]));
        end
    end

    // A live EX redirect beats a held one; EX always beats predictor.
    always_comb begin
        redir    = RD_NONE;
        redir_pc = ex_pc;
        if (!stall) begin
            if (ex_redirect) begin
                redir    = RD_EX;
                redir_pc = ex_pc;
            end else if (pend_valid && pend_ex) begin
                redir    = RD_EX;
                redir_pc = pend_pc;
            end else if (pre_redirect) begin
                redir    = RD_PRE;
                redir_pc = pre_pc;
            end else if (pend_valid) begin
                redir    = RD_PRE;
                redir_pc = pend_pc;
            end
        end
    end

    assign full = (occupancy == CW'(DEPTH));
    assign deq  = req_valid & req_ready & ~stall & (redir != RD_EX);
    assign enq  = ~stall & (redir == RD_NONE) & (~full | deq);

    always_ff @(posedge clk) begin
        if (!rst) begin
            gen_pc <= RESET_PC;
        end else if (redir != RD_NONE) begin
            gen_pc <= redir_pc;
        end else if (enq) begin
            gen_pc <= gen_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_ex    <= 1'b0;
            pend_pc    <= '0;
        end else if (!stall) begin
            pend_valid <= 1'b0;
            pend_ex    <= 1'b0;
        end else if (ex_redirect) begin
            pend_valid <= 1'b1;
            pend_ex    <= 1'b1;
            pend_pc    <= ex_pc;
        end else if (pre_redirect && !(pend_valid && pend_ex)) begin
            pend_valid <= 1'b1;
            pend_ex    <= 1'b0;
            pend_pc    <= pre_pc;
        end
    end

    fetch_req_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redir == RD_EX),
        .push  (enq),
        .pop   (deq),
        .din   ({gen_pc, gen_mask}),
        .dout  (head),
        .count (occupancy)
    );

    assign req_valid = (occupancy != '0);
    assign req_pc    = head[EW-1:FETCH_W];
    assign req_mask  = head[FETCH_W-1:0];

endmodule
